// File: rtl/loop_led_pkg.sv
// rtl/loop_led_pkg.sv - mode/direction encodings and pattern period helper for the LED stepper
package loop_led_pkg;

    typedef enum logic [1:0] {
        MODE_ROT_L  = 2'b00,
        MODE_ROT_R  = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_BLINK  = 2'b11
    } mode_t;

    typedef enum logic {
        DIR_L = 1'b0,
        DIR_R = 1'b1
    } dir_t;

    // Number of steps before the pattern returns to its starting state
    function automatic int period(input mode_t mode, input int led_num);
        case (mode)
            MODE_ROT_L, MODE_ROT_R: period = led_num;
            MODE_BOUNCE:            period = 2 * led_num - 2;
            default:                period = 2;
        endcase
    endfunction

endpackage

// File: rtl/step_edge_det.sv
// rtl/step_edge_det.sv - three-flop synchroniser with one-cycle rising-edge pulse
module step_edge_det (
    input  logic CLK_In,
    input  logic RST,
    input  logic Step_In,
    output logic Step_Pulse
);

    logic s1, s2, s3;

    always_ff @(posedge CLK_In or negedge RST) begin
        if (!RST) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= Step_In;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign Step_Pulse = s2 & ~s3;

endmodule

// File: rtl/loop_led_stepper.sv
// rtl/loop_led_stepper.sv - running-LED pattern engine advanced by divided-clock edges
module loop_led_stepper
    import loop_led_pkg::*;
#(
    parameter int                 LED_NUM  = 8,
    parameter logic [LED_NUM-1:0] INIT_PAT = LED_NUM'(1)
) (
    input  logic               CLK_In,
    input  logic               RST,
    input  logic               Step_In,
    input  logic               Run,
    input  logic [1:0]         Mode,
    input  logic               Load,
    input  logic [LED_NUM-1:0] Pat_In,
    output logic [LED_NUM-1:0] LED_Out,
    output logic               Wrap_Out
);

    localparam int CW = $clog2(2 * LED_NUM);

    logic               step_pulse;
    mode_t              mode_q;
    mode_t              mode_cur;
    dir_t               dir_q, dir_d;
    logic [CW-1:0]      cnt_q, cnt_d, cnt_last;
    logic [LED_NUM-1:0] led_d, rot_l, rot_r;
    logic               wrap_d;

    // The detector keeps tracking Step_In while Run is low so resuming never fakes an edge
    step_edge_det u_step_edge_det (
        .CLK_In     (CLK_In),
        .RST        (RST),
        .Step_In    (Step_In),
        .Step_Pulse (step_pulse)
    );

    assign mode_cur = mode_t'(Mode);
    assign rot_l    = {LED_Out[LED_NUM-2:0], LED_Out[LED_NUM-1]};
    assign rot_r    = {LED_Out[0], LED_Out[LED_NUM-1:1]};

    always_comb begin
        led_d    = LED_Out;
        dir_d    = dir_q;
        cnt_d    = cnt_q;
        wrap_d   = 1'b0;
        cnt_last = CW'(period(mode_q, LED_NUM) - 1);
        if (Load) begin
            led_d = Pat_In;
            cnt_d = '0;
            dir_d = DIR_L;
        end else if (mode_cur != mode_q) begin
            cnt_d = '0;
            dir_d = DIR_L;
        end else if (step_pulse && Run) begin
            case (mode_q)
                MODE_ROT_L: led_d = rot_l;
                MODE_ROT_R: led_d = rot_r;
                MODE_BOUNCE: begin
                    // Reverse on the step that would carry the lit end past the edge
                    if (dir_q == DIR_L) begin
                        if (LED_Out[LED_NUM-1]) begin
                            dir_d = DIR_R;
                            led_d = rot_r;
                        end else begin
                            led_d = rot_l;
                        end
                    end else begin
                        if (LED_Out[0]) begin
                            dir_d = DIR_L;
                            led_d = rot_l;
                        end else begin
                            led_d = rot_r;
                        end
                    end
                end
                default: led_d = ~LED_Out;
            endcase
            if (cnt_q == cnt_last) begin
                cnt_d  = '0;
                wrap_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK_In or negedge RST) begin
        if (!RST) begin
            mode_q   <= MODE_ROT_L;
            dir_q    <= DIR_L;
            cnt_q    <= '0;
            LED_Out  <= INIT_PAT;
            Wrap_Out <= 1'b0;
        end else begin
            mode_q   <= mode_cur;
            dir_q    <= dir_d;
            cnt_q    <= cnt_d;
            LED_Out  <= led_d;
            Wrap_Out <= wrap_d;
        end
    end

endmodule

// File: tb/tb_loop_led_stepper.sv
// tb/tb_loop_led_stepper.sv - directed self-checking bench for loop_led_stepper
module tb_loop_led_stepper;

    logic       CLK_In = 1'b0;
    logic       RST;
    logic       Step_In;
    logic       Run;
    logic [1:0] Mode;
    logic       Load;
    logic [7:0] Pat_In;
    logic [7:0] LED_Out;
    logic       Wrap_Out;

    int n_tests = 0;
    int n_fail  = 0;
    int wraps;

    logic [7:0] rotl_exp   [8]  = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
    logic [7:0] bounce_exp [15] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                    8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
    logic [7:0] blink_exp  [3]  = '{8'h5A, 8'hA5, 8'h5A};

    always #5 CLK_In = ~CLK_In;

    loop_led_stepper #(.LED_NUM(8), .INIT_PAT(8'h01)) dut (
        .CLK_In   (CLK_In),
        .RST      (RST),
        .Step_In  (Step_In),
        .Run      (Run),
        .Mode     (Mode),
        .Load     (Load),
        .Pat_In   (Pat_In),
        .LED_Out  (LED_Out),
        .Wrap_Out (Wrap_Out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One Step_In period (8 high, 8 low), counting Wrap_Out cycles seen
    task automatic step_period(output int w);
        w = 0;
        Step_In = 1'b1;
        repeat (8) begin
            @(negedge CLK_In);
            w += int'(Wrap_Out);
        end
        Step_In = 1'b0;
        repeat (8) begin
            @(negedge CLK_In);
            w += int'(Wrap_Out);
        end
    endtask

    // Period whose step edge coincides with a one-cycle Load or Mode strobe
    task automatic step_with_strobe(input logic do_load, input logic [1:0] new_mode,
                                    output int w);
        w = 0;
        Step_In = 1'b1;
        repeat (2) begin
            @(negedge CLK_In);
            w += int'(Wrap_Out);
        end
        if (do_load) begin
            Load   = 1'b1;
            Pat_In = 8'h3C;
        end else begin
            Mode = new_mode;
        end
        @(negedge CLK_In);
        w += int'(Wrap_Out);
        Load = 1'b0;
        repeat (5) begin
            @(negedge CLK_In);
            w += int'(Wrap_Out);
        end
        Step_In = 1'b0;
        repeat (8) begin
            @(negedge CLK_In);
            w += int'(Wrap_Out);
        end
    endtask

    initial begin
        int wsum;
        RST = 1'b0; Step_In = 1'b0; Run = 1'b1; Mode = 2'b00; Load = 1'b0; Pat_In = 8'h00;
        repeat (3) @(negedge CLK_In);
        check("reset_led", 32'(LED_Out), 32'h01);
        check("reset_wrap", 32'(Wrap_Out), 32'h0);
        RST = 1'b1;
        repeat (2) @(negedge CLK_In);

        for (int i = 0; i < 8; i++) begin
            step_period(wraps);
            check($sformatf("rotl_led_%0d", i), 32'(LED_Out), 32'(rotl_exp[i]));
            check($sformatf("rotl_wrap_%0d", i), 32'(wraps), (i == 7) ? 32'd1 : 32'd0);
        end

        Mode = 2'b10;
        @(negedge CLK_In);
        check("bounce_entry_led", 32'(LED_Out), 32'h01);
        for (int i = 0; i < 15; i++) begin
            step_period(wraps);
            check($sformatf("bounce_led_%0d", i), 32'(LED_Out), 32'(bounce_exp[i]));
            check($sformatf("bounce_wrap_%0d", i), 32'(wraps), (i == 13) ? 32'd1 : 32'd0);
        end

        Load = 1'b1; Pat_In = 8'hA5;
        @(negedge CLK_In);
        Load = 1'b0;
        check("load_led", 32'(LED_Out), 32'hA5);
        Mode = 2'b11;
        @(negedge CLK_In);
        check("blink_entry_led", 32'(LED_Out), 32'hA5);
        for (int i = 0; i < 3; i++) begin
            step_period(wraps);
            check($sformatf("blink_led_%0d", i), 32'(LED_Out), 32'(blink_exp[i]));
            check($sformatf("blink_wrap_%0d", i), 32'(wraps), (i == 1) ? 32'd1 : 32'd0);
        end

        Run = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step_period(wraps);
            check($sformatf("gate_led_%0d", i), 32'(LED_Out), 32'h5A);
            check($sformatf("gate_wrap_%0d", i), 32'(wraps), 32'd0);
        end
        Step_In = 1'b1;
        repeat (4) @(negedge CLK_In);
        Run = 1'b1;
        repeat (4) @(negedge CLK_In);
        Step_In = 1'b0;
        wsum = 0;
        repeat (8) begin
            @(negedge CLK_In);
            wsum += int'(Wrap_Out);
        end
        check("resume_high_led", 32'(LED_Out), 32'h5A);
        check("resume_high_wrap", 32'(wsum), 32'd0);
        step_period(wraps);
        check("resume_step_led", 32'(LED_Out), 32'hA5);
        check("resume_step_wrap", 32'(wraps), 32'd1);

        Mode = 2'b00;
        @(negedge CLK_In);
        step_period(wraps);
        step_period(wraps);
        step_period(wraps);
        check("pre_load_led", 32'(LED_Out), 32'h2D);
        step_with_strobe(1'b1, 2'b00, wraps);
        check("load_step_led", 32'(LED_Out), 32'h3C);
        check("load_step_wrap", 32'(wraps), 32'd0);
        wsum = 0;
        for (int i = 0; i < 7; i++) begin
            step_period(wraps);
            wsum += wraps;
        end
        check("load_cnt_led7", 32'(LED_Out), 32'h1E);
        check("load_cnt_wrap7", 32'(wsum), 32'd0);
        step_period(wraps);
        check("load_cnt_led8", 32'(LED_Out), 32'h3C);
        check("load_cnt_wrap8", 32'(wraps), 32'd1);

        step_period(wraps);
        step_period(wraps);
        check("pre_mode_led", 32'(LED_Out), 32'hF0);
        step_with_strobe(1'b0, 2'b01, wraps);
        check("mode_step_led", 32'(LED_Out), 32'hF0);
        check("mode_step_wrap", 32'(wraps), 32'd0);
        wsum = 0;
        for (int i = 0; i < 7; i++) begin
            step_period(wraps);
            wsum += wraps;
        end
        check("mode_cnt_led7", 32'(LED_Out), 32'hE1);
        check("mode_cnt_wrap7", 32'(wsum), 32'd0);
        step_period(wraps);
        check("mode_cnt_led8", 32'(LED_Out), 32'hF0);
        check("mode_cnt_wrap8", 32'(wraps), 32'd1);

        for (int i = 0; i < 5; i++) step_period(wraps);
        check("rotr5_led", 32'(LED_Out), 32'h87);
        @(posedge CLK_In);
        #2;
        RST = 1'b0;
        #1;
        check("async_rst_led", 32'(LED_Out), 32'h01);
        check("async_rst_wrap", 32'(Wrap_Out), 32'h0);
        Mode = 2'b00;
        Step_In = 1'b1;
        repeat (2) @(negedge CLK_In);
        RST = 1'b1;
        @(negedge CLK_In);
        check("rel_edge1_led", 32'(LED_Out), 32'h01);
        @(negedge CLK_In);
        check("rel_edge2_led", 32'(LED_Out), 32'h01);
        @(negedge CLK_In);
        check("rel_edge3_led", 32'(LED_Out), 32'h02);
        repeat (4) @(negedge CLK_In);
        Step_In = 1'b0;
        repeat (8) @(negedge CLK_In);
        check("rel_single_step", 32'(LED_Out), 32'h02);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
